// File: rtl/ysyx_22041412_icache_pkg.sv
// Shared types and width helpers for the parametrised instruction cache.
package ysyx_22041412_icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_FILL,
    S_FLUSH
  } state_e;

  function automatic int calc_off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int line_bytes, input int sets);
    return addr_w - $clog2(line_bytes) - $clog2(sets);
  endfunction

  function automatic int calc_beats(input int line_bytes, input int axi_dw);
    return line_bytes * 8 / axi_dw;
  endfunction

  // A direct-mapped cache still needs a one-bit way select.
  function automatic int calc_way_w(input int ways);
    return (ways < 2) ? 1 : $clog2(ways);
  endfunction

endpackage

// File: rtl/ysyx_22041412_icache_way_ram.sv
// One way of line storage: synchronous read, single write port.
module ysyx_22041412_icache_way_ram
  import ysyx_22041412_icache_pkg::*;
#(
  parameter int SETS   = 64,
  parameter int LINE_W = 128,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [LINE_W-1:0] wr_data
);

  logic [LINE_W-1:0] mem [SETS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ysyx_22041412_icache_param.sv
// Set-associative read-only instruction cache with burst refill, invalid-first
// plus round-robin replacement, and a fence_i whole-cache invalidate.
module ysyx_22041412_icache_param
  import ysyx_22041412_icache_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  parameter int AXI_DW     = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_valid,
  input  logic [ADDR_W-1:0]       cpu_req_addr,
  output logic                    cpu_ready,
  output logic [LINE_BYTES*8-1:0] cpu_read_data,
  input  logic                    fence_i,
  output logic                    flush_busy,
  output logic                    axi_valid_o,
  output logic [ADDR_W-1:0]       axi_r_addr_o,
  output logic [7:0]              axi_r_len_o,
  input  logic                    axi_ready_i,
  input  logic [AXI_DW-1:0]       axi_r_data_i,
  input  logic                    axi_r_last_i,
  output logic [63:0]             cache_hit,
  output logic [63:0]             cache_miss
);

  localparam int OFF_W  = calc_off_w(LINE_BYTES);
  localparam int IDX_W  = calc_idx_w(SETS);
  localparam int TAG_W  = calc_tag_w(ADDR_W, LINE_BYTES, SETS);
  localparam int BEATS  = calc_beats(LINE_BYTES, AXI_DW);
  localparam int WAY_W  = calc_way_w(WAYS);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int LA_W   = ADDR_W - OFF_W;

  state_e             state;
  logic [LA_W-1:0]    req_line_q;
  logic [7:0]         beat_cnt;
  logic [LINE_W-1:0]  fill_buf;
  logic [LINE_W-1:0]  fill_next;
  logic [IDX_W-1:0]   flush_idx;
  logic               fence_pend;
  logic [SETS-1:0]    valid_q [WAYS];
  logic [TAG_W-1:0]   tag_q [WAYS][SETS];
  logic [WAY_W-1:0]   rr_q [SETS];
  logic [LINE_W-1:0]  way_rdata [WAYS];
  logic [WAYS-1:0]    way_we;

  logic [IDX_W-1:0]   cpu_idx;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               unused_off;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [LINE_W-1:0]  hit_data;
  logic               has_inv;
  logic [WAY_W-1:0]   victim;
  logic               last_beat;

  assign cpu_idx    = cpu_req_addr[OFF_W +: IDX_W];
  assign unused_off = ^cpu_req_addr[OFF_W-1:0];
  assign req_idx    = req_line_q[IDX_W-1:0];
  assign req_tag    = req_line_q[IDX_W +: TAG_W];
  assign last_beat  = axi_ready_i && (axi_r_last_i || beat_cnt == 8'(BEATS - 1));

  // Descending scans leave the lowest matching / invalid way selected.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_inv  = 1'b0;
    victim   = rr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][req_idx]) begin
        has_inv = 1'b1;
        victim  = WAY_W'(w);
      end
    end
  end

  always_comb begin
    hit_data = '0;
    way_we   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_way == WAY_W'(w)) hit_data = way_rdata[w];
      way_we[w] = (state == S_FILL) && (victim == WAY_W'(w));
    end
  end

  always_comb begin
    fill_next = fill_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt == 8'(b)) fill_next[b*AXI_DW +: AXI_DW] = axi_r_data_i;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ysyx_22041412_icache_way_ram #(
      .SETS   (SETS),
      .LINE_W (LINE_W),
      .IDX_W  (IDX_W)
    ) u_ram (
      .clk     (clk),
      .rd_en   (state == S_IDLE),
      .rd_idx  (cpu_idx),
      .rd_data (way_rdata[w]),
      .wr_en   (way_we[w]),
      .wr_idx  (req_idx),
      .wr_data (fill_buf)
    );
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (way_we[w]) tag_q[w][req_idx] <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_line_q    <= '0;
      beat_cnt      <= '0;
      fill_buf      <= '0;
      flush_idx     <= '0;
      fence_pend    <= 1'b0;
      cpu_ready     <= 1'b0;
      cpu_read_data <= '0;
      flush_busy    <= 1'b0;
      axi_valid_o   <= 1'b0;
      axi_r_addr_o  <= '0;
      axi_r_len_o   <= '0;
      cache_hit     <= '0;
      cache_miss    <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      cpu_ready <= 1'b0;
      if (fence_i && state != S_IDLE) fence_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (fence_i || fence_pend) begin
            fence_pend <= 1'b0;
            flush_busy <= 1'b1;
            flush_idx  <= '0;
            state      <= S_FLUSH;
          end else if (cpu_valid && !cpu_ready) begin
            req_line_q <= cpu_req_addr[ADDR_W-1:OFF_W];
            state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            cpu_ready     <= 1'b1;
            cpu_read_data <= hit_data;
            cache_hit     <= cache_hit + 64'd1;
            state         <= S_IDLE;
          end else begin
            cache_miss   <= cache_miss + 64'd1;
            axi_valid_o  <= 1'b1;
            axi_r_addr_o <= {req_line_q, OFF_W'(0)};
            axi_r_len_o  <= 8'(BEATS - 1);
            beat_cnt     <= '0;
            fill_buf     <= '0;
            state        <= S_MISS;
          end
        end
        S_MISS: begin
          if (axi_ready_i) begin
            fill_buf <= fill_next;
            beat_cnt <= beat_cnt + 8'd1;
            // The assembled line is returned during FILL, one cycle after the last beat.
            if (last_beat) begin
              axi_valid_o   <= 1'b0;
              cpu_ready     <= 1'b1;
              cpu_read_data <= fill_next;
              state         <= S_FILL;
            end
          end
        end
        S_FILL: begin
          for (int w = 0; w < WAYS; w++) begin
            if (victim == WAY_W'(w)) valid_q[w][req_idx] <= 1'b1;
          end
          if (!has_inv) begin
            rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
          end
          state <= S_IDLE;
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) valid_q[w][flush_idx] <= 1'b0;
          rr_q[flush_idx] <= '0;
          if (flush_idx == IDX_W'(SETS - 1)) begin
            flush_busy <= 1'b0;
            state      <= S_IDLE;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_icache_param.sv
// Scoreboard bench for the instruction cache: a small AXI memory model answers
// refills, expected lines are queued per request and compared on cpu_ready.
module tb_ysyx_22041412_icache_param;

  localparam int WAYS       = 4;
  localparam int SETS       = 64;
  localparam int LINE_BYTES = 16;
  localparam int ADDR_W     = 32;
  localparam int AXI_DW     = 64;
  localparam int BEATS      = LINE_BYTES * 8 / AXI_DW;
  localparam int LINE_W     = LINE_BYTES * 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cpu_valid;
  logic [ADDR_W-1:0]   cpu_req_addr;
  logic                cpu_ready;
  logic [LINE_W-1:0]   cpu_read_data;
  logic                fence_i;
  logic                flush_busy;
  logic                axi_valid_o;
  logic [ADDR_W-1:0]   axi_r_addr_o;
  logic [7:0]          axi_r_len_o;
  logic                axi_ready_i;
  logic [AXI_DW-1:0]   axi_r_data_i;
  logic                axi_r_last_i;
  logic [63:0]         cache_hit;
  logic [63:0]         cache_miss;

  int                  n_cmp = 0;
  int                  n_bad = 0;
  longint              exp_hits = 0;
  longint              exp_misses = 0;
  logic [LINE_W-1:0]   exp_q [$];

  always #5 clk = ~clk;

  ysyx_22041412_icache_param #(
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_BYTES (LINE_BYTES),
    .ADDR_W     (ADDR_W),
    .AXI_DW     (AXI_DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_valid     (cpu_valid),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_ready     (cpu_ready),
    .cpu_read_data (cpu_read_data),
    .fence_i       (fence_i),
    .flush_busy    (flush_busy),
    .axi_valid_o   (axi_valid_o),
    .axi_r_addr_o  (axi_r_addr_o),
    .axi_r_len_o   (axi_r_len_o),
    .axi_ready_i   (axi_ready_i),
    .axi_r_data_i  (axi_r_data_i),
    .axi_r_last_i  (axi_r_last_i),
    .cache_hit     (cache_hit),
    .cache_miss    (cache_miss)
  );

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: the first line holds the recognisable 0x1111/0x2222 pattern.
  function automatic logic [AXI_DW-1:0] exp_beat(input logic [ADDR_W-1:0] line, input int i);
    if (line == 32'h8000_0000) return (i == 0) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222;
    return {line, 24'hC0FFEE, 8'(i)};
  endfunction

  function automatic logic [LINE_W-1:0] exp_line(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] base;
    logic [LINE_W-1:0] l;
    base = a & ~ADDR_W'(LINE_BYTES - 1);
    l = '0;
    for (int i = 0; i < BEATS; i++) l[i*AXI_DW +: AXI_DW] = exp_beat(base, i);
    return l;
  endfunction

  // One fetch: drive the request, answer any refill, compare when cpu_ready shows.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input bit expect_hit,
                               input bit gap, input int fence_at);
    int t;
    int beat;
    int last_t;
    bit saw_axi;
    bit done;
    logic [ADDR_W-1:0] base;
    t = 0; beat = 0; last_t = -1; saw_axi = 0; done = 0;
    base = addr & ~ADDR_W'(LINE_BYTES - 1);
    exp_q.push_back(exp_line(addr));
    @(negedge clk);
    cpu_valid    = 1'b1;
    cpu_req_addr = addr;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
      axi_ready_i  = 1'b0;
      axi_r_last_i = 1'b0;
      fence_i      = (t == fence_at);
      if (cpu_ready) begin
        done      = 1;
        cpu_valid = 1'b0;
        checkOutput("line", cpu_read_data, exp_q.pop_front());
        if (expect_hit) checkOutput("hit_latency", t, 2);
        else            checkOutput("miss_latency", t, last_t + 1);
      end else if (axi_valid_o) begin
        if (!saw_axi) begin
          saw_axi = 1;
          checkOutput("axi_addr", axi_r_addr_o, base);
          checkOutput("axi_len", axi_r_len_o, BEATS - 1);
        end
        if (beat < BEATS && (!gap || t % 2 == 0)) begin
          axi_ready_i  = 1'b1;
          axi_r_data_i = exp_beat(axi_r_addr_o, beat);
          axi_r_last_i = (beat == BEATS - 1);
          last_t       = t;
          beat++;
        end
      end
    end
    fence_i = 1'b0;
    if (!done) begin
      checkOutput("ready_timeout", 0, 1);
      cpu_valid = 1'b0;
      void'(exp_q.pop_front());
    end
    checkOutput("axi_used", saw_axi, !expect_hit);
    if (expect_hit) exp_hits++;
    else            exp_misses++;
    checkOutput("hits", cache_hit, exp_hits);
    checkOutput("misses", cache_miss, exp_misses);
  endtask

  task automatic waitFlush(output int delay, output int count);
    delay = 0;
    count = 0;
    while (!flush_busy && delay < 10) begin
      @(negedge clk);
      fence_i = 1'b0;
      delay++;
    end
    while (flush_busy && count < 200) begin
      @(negedge clk);
      count++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    int c;
    int k;
    logic [ADDR_W-1:0] ra;
    rst_n        = 1'b0;
    cpu_valid    = 1'b0;
    cpu_req_addr = '0;
    fence_i      = 1'b0;
    axi_ready_i  = 1'b0;
    axi_r_data_i = '0;
    axi_r_last_i = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_ready", cpu_ready, 0);
    checkOutput("rst_axi_valid", axi_valid_o, 0);
    checkOutput("rst_flush_busy", flush_busy, 0);
    checkOutput("rst_data", cpu_read_data, 0);
    checkOutput("rst_len", axi_r_len_o, 0);
    checkOutput("rst_addr", axi_r_addr_o, 0);
    checkOutput("rst_hits", cache_hit, 0);
    checkOutput("rst_misses", cache_miss, 0);
    rst_n = 1'b1;

    applyStimulus(32'h8000_0000, 0, 0, 0);
    checkOutput("cold_line_literal", cpu_read_data,
                {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    applyStimulus(32'h8000_0000, 1, 0, 0);
    applyStimulus(32'h8000_000C, 1, 0, 0);

    // Same set, distinct tags: fill ways 1..3, then evict round-robin.
    for (k = 1; k <= 4; k++) applyStimulus(32'h8000_0000 + 32'(k) * 32'h400, 0, k == 2, 0);
    applyStimulus(32'h8000_0400, 1, 0, 0);
    applyStimulus(32'h8000_1000, 1, 0, 0);
    applyStimulus(32'h8000_0000, 0, 0, 0);
    applyStimulus(32'h8000_0800, 1, 0, 0);
    applyStimulus(32'h8000_0400, 0, 0, 0);
    applyStimulus(32'h8000_0C00, 1, 0, 0);

    @(negedge clk);
    fence_i = 1'b1;
    waitFlush(d, c);
    checkOutput("flush_delay_idle", d, 1);
    checkOutput("flush_cycles_idle", c, SETS);
    applyStimulus(32'h8000_0000, 0, 0, 0);
    applyStimulus(32'h8000_0C00, 0, 0, 0);

    applyStimulus(32'h8000_2000, 0, 1, 3);
    waitFlush(d, c);
    checkOutput("flush_delay_pending", d, 2);
    checkOutput("flush_cycles_pending", c, SETS);
    applyStimulus(32'h8000_2000, 0, 0, 0);

    // Reset in the middle of a refill.
    ra = 32'h8000_1230;
    @(negedge clk);
    cpu_valid    = 1'b1;
    cpu_req_addr = ra;
    d = 0;
    while (!axi_valid_o && d < 10) begin
      @(negedge clk);
      d++;
    end
    checkOutput("abort_axi_seen", axi_valid_o, 1);
    axi_ready_i  = 1'b1;
    axi_r_data_i = exp_beat(axi_r_addr_o, 0);
    axi_r_last_i = 1'b0;
    @(negedge clk);
    axi_ready_i = 1'b0;
    cpu_valid   = 1'b0;
    rst_n       = 1'b0;
    #1;
    checkOutput("abort_axi_valid", axi_valid_o, 0);
    checkOutput("abort_ready", cpu_ready, 0);
    checkOutput("abort_hits", cache_hit, 0);
    checkOutput("abort_misses", cache_miss, 0);
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(ra, 0, 0, 0);
    applyStimulus(32'h8000_0000, 0, 0, 0);
    applyStimulus(ra, 1, 0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
